mb_debug_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file for the MicroBlaze debug peripheral, successor to the fixed four-register debug slave. It provides NUM_REGS software-visible registers with byte-strobe writes, independent acceptance of the AW and W channels, and SLVERR responses for out-of-range accesses. It also emits per-register write pulses and can optionally expose read-only hardware status words. It sits behind the AXI interconnect at the debug peripheral base address, and its register contents drive debug/control logic in the fabric.

---
 rtl/mb_debug_regfile.sv | 145 ++++++++++++++
 tb/tb_mb_debug_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_debug_regfile.sv
// AXI4-Lite slave register file for the MicroBlaze debug peripheral.
// Define MB_DEBUG_RO_STATUS_EN to turn the top NUM_RO registers into read-only status words.
module mb_debug_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS           = 8,
  parameter int unsigned NUM_RO             = 2,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned OffW = $clog2(SW);
  localparam int unsigned IdxW = $clog2(NUM_REGS);
  localparam int unsigned TopW = OffW + IdxW;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [DW-1:0]                 regs_q [NUM_REGS];
  logic                          aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]                 w_data_q, rdata_q;
  logic [SW-1:0]                 w_strb_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [NUM_REGS-1:0]           wr_pulse_q, ro_mask;
  logic [IdxW-1:0]               w_idx, r_idx;
  logic                          w_oor, r_oor, w_err, commit, awready, wready;
  logic [DW-1:0]                 r_word;
  logic                          unused;

  always_comb begin
    ro_mask = '0;
`ifdef MB_DEBUG_RO_STATUS_EN
    for (int i = 0; i < int'(NUM_REGS); i++) ro_mask[i] = (i >= int'(NUM_REGS - NUM_RO));
`endif
  end

  // RO slices mirror the live status word so fabric logic sees one uniform map.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = ro_mask[g] ? status_in[g*DW +: DW] : regs_q[g];
  end

  assign w_idx  = aw_addr_q[OffW +: IdxW];
  assign w_oor  = (aw_addr_q >> TopW) != '0;
  assign w_err  = w_oor || ro_mask[w_idx];
  assign r_idx  = S_AXI_ARADDR[OffW +: IdxW];
  assign r_oor  = (S_AXI_ARADDR >> TopW) != '0;
  assign r_word = reg_out[r_idx*DW +: DW];

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q && !bvalid_q;
  assign commit  = aw_held_q && w_held_q && !bvalid_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      wr_pulse_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= RESET_VALUE;
    end else begin
      wr_pulse_q <= '0;
      if (S_AXI_AWVALID && awready) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && wready) begin
        w_held_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= w_err ? RespSlverr : RespOkay;
        if (!w_err) begin
          wr_pulse_q[w_idx] <= 1'b1;
          for (int b = 0; b < int'(SW); b++) begin
            if (w_strb_q[b]) regs_q[w_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read sampling uses pre-edge register contents, so a same-cycle commit is not visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else if (S_AXI_ARVALID && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= r_oor ? '0 : r_word;
      rresp_q  <= r_oor ? RespSlverr : RespOkay;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_in, aw_addr_q[OffW-1:0],
                    S_AXI_ARADDR[OffW-1:0], NUM_RO != 0};

endmodule

// File: tb/tb_mb_debug_regfile.sv
// Self-checking bench for mb_debug_regfile: directed table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_mb_debug_regfile;
  localparam int NR = 8;
  localparam int NumRo = 2;
`ifdef MB_DEBUG_RO_STATUS_EN
  localparam bit RoEn = 1'b1;
`else
  localparam bit RoEn = 1'b0;
`endif

  logic         ACLK, ARESETN;
  logic [7:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [255:0] reg_out, status_in;
  logic [7:0]   wr_pulse;

  mb_debug_regfile #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_REGS(8), .NUM_RO(2),
    .RESET_VALUE(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    int         lead;
    logic [1:0] resp;
    logic [31:0] rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model [NR];
  logic [31:0] status [NR];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int lead, input logic [1:0] resp,
                              input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.lead = lead; v.resp = resp; v.rdata = rdata;
    return v;
  endfunction

  function automatic int idx_of(input logic [7:0] a);
    return (int'(a) / 4) % NR;
  endfunction
  function automatic bit oor_of(input logic [7:0] a);
    return int'(a) >= 4 * NR;
  endfunction
  function automatic bit ro_of(input int idx);
    return RoEn && idx >= NR - NumRo;
  endfunction
  function automatic logic [31:0] exp_read(input logic [7:0] a);
    if (oor_of(a)) return 32'h0;
    if (ro_of(idx_of(a))) return status[idx_of(a)];
    return model[idx_of(a)];
  endfunction
  function automatic void model_apply(input int idx, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask |= 32'hFF << (8 * b);
    model[idx] = (model[idx] & ~mask) | (data & mask);
  endfunction

  task automatic push_status();
    for (int i = 0; i < NR; i++) status_in[i*32 +: 32] = status[i];
  endtask

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int bdelay,
                          output logic [1:0] resp, output logic [7:0] pulses, output int npulse);
    int cyc, aw_at, w_at, lat;
    bit aw_done, w_done, aw_hs, w_hs, bp_ok;
    aw_at = lead > 0 ? lead : 0;
    w_at  = lead < 0 ? -lead : 0;
    aw_done = 0; w_done = 0; pulses = '0; npulse = 0; cyc = 0; bp_ok = 1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      S_AXI_AWVALID = !aw_done && cyc >= aw_at;
      S_AXI_WVALID  = !w_done && cyc >= w_at;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      aw_done |= aw_hs; w_done |= w_hs;
      pulses |= wr_pulse; npulse += $countones(wr_pulse);
      cyc++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    lat = 0;
    while (!S_AXI_BVALID && lat < 20) begin
      @(negedge ACLK);
      lat++;
      pulses |= wr_pulse; npulse += $countones(wr_pulse);
    end
    check($sformatf("bvalid latency @%02h", addr), lat, 1);
    resp = S_AXI_BRESP;
    for (int i = 0; i < bdelay; i++) begin
      if (S_AXI_AWREADY || S_AXI_WREADY || !S_AXI_BVALID) bp_ok = 0;
      @(negedge ACLK);
      pulses |= wr_pulse; npulse += $countones(wr_pulse);
    end
    if (S_AXI_AWREADY || S_AXI_WREADY) bp_ok = 0;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    pulses |= wr_pulse; npulse += $countones(wr_pulse);
    S_AXI_BREADY = 1'b0;
    check($sformatf("ready low while bvalid @%02h", addr), bp_ok, 1);
    check($sformatf("bvalid cleared @%02h", addr), S_AXI_BVALID, 0);
  endtask

  task automatic do_read(input logic [7:0] addr, input int rdelay,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit hs, stable;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; hs = 0; cyc = 0; stable = 1;
    while (!hs && cyc < 20) begin
      hs = S_AXI_ARREADY;
      @(negedge ACLK);
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    check($sformatf("rvalid after ar @%02h", addr), S_AXI_RVALID, 1);
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge ACLK);
      if (S_AXI_RDATA !== data || !S_AXI_RVALID) stable = 0;
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check($sformatf("rdata stable @%02h", addr), stable, 1);
    check($sformatf("rvalid cleared @%02h", addr), S_AXI_RVALID, 0);
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int bdelay);
    logic [1:0] resp;
    logic [7:0] pulses;
    int npulse, idx;
    bit ok;
    idx = idx_of(addr);
    ok = !oor_of(addr) && !ro_of(idx);
    do_write(addr, data, strb, lead, bdelay, resp, pulses, npulse);
    check($sformatf("bresp @%02h", addr), resp, ok ? 2'b00 : 2'b10);
    check($sformatf("wr_pulse @%02h", addr), pulses, ok ? 8'(1 << idx) : 8'h0);
    check($sformatf("pulse count @%02h", addr), npulse, ok ? 1 : 0);
    if (ok) model_apply(idx, data, strb);
  endtask

  task automatic model_read(input logic [7:0] addr, input int rdelay);
    logic [31:0] data;
    logic [1:0] resp;
    do_read(addr, rdelay, data, resp);
    check($sformatf("rdata @%02h", addr), data, exp_read(addr));
    check($sformatf("rresp @%02h", addr), resp, oor_of(addr) ? 2'b10 : 2'b00);
  endtask

  task automatic check_reg_out();
    for (int i = 0; i < NR; i++)
      check($sformatf("reg_out[%0d]", i), reg_out[i*32 +: 32], ro_of(i) ? status[i] : model[i]);
  endtask

  initial begin
    logic [1:0] resp;
    logic [7:0] pulses;
    logic [31:0] rdata;
    int npulse;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0;
    S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0;
    S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < NR; i++) begin
      model[i] = 32'h0;
      status[i] = 32'h5A000000 + 32'(i);
    end
    status[6] = 32'h600DF00D;
    status[7] = 32'hDEADBEEF;
    push_status();
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    check("reset bvalid", S_AXI_BVALID, 0);
    check("reset rvalid", S_AXI_RVALID, 0);
    check("reset wr_pulse", wr_pulse, 0);
    check("reset awready", S_AXI_AWREADY, 1);
    check("reset wready", S_AXI_WREADY, 1);
    check("reset arready", S_AXI_ARREADY, 1);
    check("reset rdata", S_AXI_RDATA, 0);
    check_reg_out();

    // Directed table.
    for (int i = 0; i < NR; i++)
      vecs.push_back(mk(1'b1, 8'(4 * i), 32'(i + 1), 4'hF, (i % 3) - 1,
                        (RoEn && i >= NR - NumRo) ? 2'b10 : 2'b00, 32'h0));
    for (int i = 0; i < NR; i++)
      vecs.push_back(mk(1'b0, 8'(4 * i), 32'h0, 4'h0, 0, 2'b00,
                        (RoEn && i >= NR - NumRo) ? status[i] : 32'(i + 1)));
    vecs.push_back(mk(1'b1, 8'h04, 32'hAABBCCDD, 4'hF, 0, 2'b00, 32'h0));
    vecs.push_back(mk(1'b1, 8'h04, 32'h11223344, 4'h5, 2, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 8'h04, 32'h0, 4'h0, 0, 2'b00, 32'hAA22CC44));
    vecs.push_back(mk(1'b1, 8'h0B, 32'h00000055, 4'h1, -2, 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 8'h08, 32'h0, 4'h0, 0, 2'b00, 32'h00000055));
    vecs.push_back(mk(1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 0, 2'b10, 32'h0));
    vecs.push_back(mk(1'b0, 8'h20, 32'h0, 4'h0, 0, 2'b10, 32'h0));
    vecs.push_back(mk(1'b0, 8'h00, 32'h0, 4'h0, 0, 2'b00, 32'h00000001));
    vecs.push_back(mk(1'b1, 8'h1C, 32'h12345678, 4'hF, 1, RoEn ? 2'b10 : 2'b00, 32'h0));
    vecs.push_back(mk(1'b0, 8'h1C, 32'h0, 4'h0, 0, 2'b00, RoEn ? 32'hDEADBEEF : 32'h12345678));
    vecs.push_back(mk(1'b0, 8'h2C, 32'h0, 4'h0, 0, 2'b10, 32'h0));

    foreach (vecs[k]) begin
      if (vecs[k].wr) begin
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].lead, 0, resp, pulses, npulse);
        check($sformatf("vec%0d bresp", k), resp, vecs[k].resp);
        check($sformatf("vec%0d wr_pulse", k), pulses,
              vecs[k].resp == 2'b00 ? 8'(1 << idx_of(vecs[k].addr)) : 8'h0);
        check($sformatf("vec%0d pulse count", k), npulse, vecs[k].resp == 2'b00 ? 1 : 0);
        if (vecs[k].resp == 2'b00) model_apply(idx_of(vecs[k].addr), vecs[k].data, vecs[k].strb);
      end else begin
        do_read(vecs[k].addr, k % 3, rdata, resp);
        check($sformatf("vec%0d rdata", k), rdata, vecs[k].rdata);
        check($sformatf("vec%0d rresp", k), resp, vecs[k].resp);
      end
    end
    check_reg_out();

    // W three cycles ahead of AW, BREADY held off for 5 cycles.
    model_write(8'h08, 32'hCAFEF00D, 4'hF, 3, 5);
    repeat (3) @(negedge ACLK);
    check("no late pulse", wr_pulse, 0);
    model_read(8'h08, 0);

    // Read and write commit hit register 3 on the same edge.
    S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h13579BDF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    check("collision awready", S_AXI_AWREADY & S_AXI_WREADY, 1);
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    check("collision rvalid", S_AXI_RVALID, 1);
    check("collision bvalid", S_AXI_BVALID, 1);
    check("collision rdata old", S_AXI_RDATA, model[3]);
    check("collision wr_pulse", wr_pulse, 8'h08);
    model_apply(3, 32'h13579BDF, 4'hF);
    S_AXI_RREADY = 1; S_AXI_BREADY = 1;
    @(negedge ACLK);
    S_AXI_RREADY = 0; S_AXI_BREADY = 0;
    model_read(8'h0C, 1);

    // Reset with both responses pending.
    S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h77777777; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    repeat (2) @(negedge ACLK);
    check("pre-reset bvalid", S_AXI_BVALID, 1);
    check("pre-reset rvalid", S_AXI_RVALID, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("mid-reset bvalid", S_AXI_BVALID, 0);
    check("mid-reset rvalid", S_AXI_RVALID, 0);
    check("mid-reset rdata", S_AXI_RDATA, 0);
    check("mid-reset bresp", S_AXI_BRESP, 0);
    check("mid-reset rresp", S_AXI_RRESP, 0);
    check("mid-reset wr_pulse", wr_pulse, 0);
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_reg_out();
    for (int i = 0; i < NR; i++) model_read(8'(4 * i), 0);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      for (int i = NR - NumRo; i < NR; i++) status[i] = $urandom;
      push_status();
      if ($urandom_range(0, 1) == 1)
        model_write(8'($urandom_range(0, 47)), $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
      else
        model_read(8'($urandom_range(0, 47)), int'($urandom_range(0, 2)));
      check_reg_out();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
